tmds_decoder: RTL and testbench

Receive-side counterpart of the team's TMDS channel encoder. It takes unaligned 10-bit parallel words from a 1:10 deserializer and locks symbol alignment by searching the 10 bit offsets for control tokens. It then decodes each aligned symbol back to 8-bit pixel data, or to the c0/c1 control pair during blanking. One instance per TMDS channel (blue/green/red) sits between the deserializer and the video timing recovery logic.

---
 rtl/tmds_decoder_if.sv | 21 ++
 rtl/tmds_decoder.sv | 137 +++++++++++++
 tb/tb_tmds_decoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tmds_decoder_if.sv
// Signal bundle between a 1:10 deserializer channel and the TMDS symbol decoder.
// master drives raw words and observes decoded symbols; slave is the decoder side.
interface tmds_decoder_if;
  logic [9:0] din;
  logic [7:0] dout;
  logic       c0;
  logic       c1;
  logic       blanking;
  logic       locked;
  logic [3:0] align_offset;

  modport master (
    output din,
    input  dout, c0, c1, blanking, locked, align_offset
  );

  modport slave (
    input  din,
    output dout, c0, c1, blanking, locked, align_offset
  );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel receiver: locks symbol alignment on runs of control tokens,
// then decodes each aligned 10-bit symbol to pixel data or the c0/c1 pair.
module tmds_decoder #(
  parameter int unsigned CTL_RUN      = 8,
  parameter int unsigned LOSS_TIMEOUT = 4096
) (
  input logic           clk,
  input logic           rst_n,
  tmds_decoder_if.slave bus
);
  localparam int unsigned LW = $clog2(LOSS_TIMEOUT);
  localparam logic [7:0]    RUN_LAST  = 8'(CTL_RUN - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_TIMEOUT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [9:0]    cur_q, prev_q;
  logic [19:0]   win;
  logic [9:0]    sym;
  logic [3:0]    off_q, off_d;
  logic [7:0]    run_q, run_d;
  logic [LW-1:0] loss_q, loss_d;
  logic          is_tok;
  logic [1:0]    tok_c;
  logic [7:0]    d;
  logic [7:0]    data;
  logic [7:0]    dout_q;
  logic          c0_q, c1_q, blank_q;

  // Bit 0 of prev_q is the earliest bit on the wire.
  assign win = {cur_q, prev_q};
  assign sym = win[{1'b0, off_q} +: 10];

  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (sym)
      10'b1101010100: tok_c = 2'b00;
      10'b0010101011: tok_c = 2'b01;
      10'b0101010100: tok_c = 2'b10;
      10'b1010101011: tok_c = 2'b11;
      default:        is_tok = 1'b0;
    endcase
  end

  always_comb begin
    d       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = '0;
    data[0] = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    run_d   = run_q;
    loss_d  = loss_q;
    case (state_q)
      SEARCH: begin
        if (is_tok) begin
          if (run_q == RUN_LAST) begin
            state_d = LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_q + 8'd1;
          end
        end else begin
          run_d = '0;
          off_d = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
        end
      end
      LOCKED: begin
        if (is_tok) begin
          loss_d = '0;
        end else if (loss_q == LOSS_LAST) begin
          state_d = SEARCH;
          loss_d  = '0;
          run_d   = '0;
        end else begin
          loss_d = loss_q + LW'(1);
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      cur_q   <= '0;
      prev_q  <= '0;
      off_q   <= '0;
      run_q   <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= bus.din;
      prev_q  <= cur_q;
      off_q   <= off_d;
      run_q   <= run_d;
      loss_q  <= loss_d;
    end
  end

  // Gated on the next state so the lock edge already carries the first decode
  // and the loss edge already shows forced blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      c0_q    <= 1'b0;
      c1_q    <= 1'b0;
      blank_q <= 1'b1;
    end else if (state_d == LOCKED) begin
      blank_q <= is_tok;
      dout_q  <= is_tok ? 8'h00 : data;
      if (is_tok) begin
        c1_q <= tok_c[1];
        c0_q <= tok_c[0];
      end
    end else begin
      dout_q  <= '0;
      c0_q    <= 1'b0;
      c1_q    <= 1'b0;
      blank_q <= 1'b1;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.c0           = c0_q;
  assign bus.c1           = c1_q;
  assign bus.blanking     = blank_q;
  assign bus.locked       = (state_q == LOCKED);
  assign bus.align_offset = off_q;
endmodule

// File: tb/tb_tmds_decoder.sv
// Directed-vector bench for tmds_decoder: expectations are queued per clock
// edge when stimulus is issued and a negedge monitor pops and compares them.
module tb_tmds_decoder;
  localparam logic [9:0] T00 = 10'h354;
  localparam logic [9:0] T01 = 10'h0AB;
  localparam logic [9:0] T10 = 10'h154;
  localparam logic [9:0] T11 = 10'h2AB;
  localparam logic [9:0] S3_FIRST = 10'h2A0; // T00 shifted to offset 3, 3 zero bits lead
  localparam logic [9:0] S3_WORD  = 10'h2A6;

  localparam bit [4:0] ML = 5'b00001;
  localparam bit [4:0] MO = 5'b00010;
  localparam bit [4:0] MB = 5'b00100;
  localparam bit [4:0] MC = 5'b01000;
  localparam bit [4:0] MD = 5'b10000;
  localparam bit [4:0] MALL = 5'b11111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tmds_decoder_if bus ();

  tmds_decoder #(.CTL_RUN(8), .LOSS_TIMEOUT(4096)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int         tag;
    string      name;
    bit [4:0]   mask;
    logic       lk;
    logic [3:0] off;
    logic       bl;
    logic [1:0] c;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int edge_n, input string nm, input bit [4:0] m,
                           input logic lk, input logic [3:0] of, input logic bl,
                           input logic [1:0] c, input logic [7:0] dv);
    exp_t e;
    e.tag  = base + edge_n;
    e.name = nm;
    e.mask = m;
    e.lk   = lk;
    e.off  = of;
    e.bl   = bl;
    e.c    = c;
    e.d    = dv;
    sb.push_back(e);
  endtask

  task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=0x%0h required=0x%0h (cycle %0d)", nm, fld, act, req, cyc);
    end
  endtask

  task automatic check_entry(input exp_t e);
    if (e.mask[0]) cmp(e.name, "locked", {7'b0, bus.locked}, {7'b0, e.lk});
    if (e.mask[1]) cmp(e.name, "align_offset", {4'b0, bus.align_offset}, {4'b0, e.off});
    if (e.mask[2]) cmp(e.name, "blanking", {7'b0, bus.blanking}, {7'b0, e.bl});
    if (e.mask[3]) cmp(e.name, "c1c0", {6'b0, bus.c1, bus.c0}, {6'b0, e.c});
    if (e.mask[4]) cmp(e.name, "dout", bus.dout, e.d);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].tag == cyc) begin
        check_entry(sb[i]);
        sb.delete(i);
      end else if (sb[i].tag < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s not sampled actual_cycle=%0d required_cycle=%0d", sb[i].name, cyc, sb[i].tag);
        sb.delete(i);
      end
    end
  end

  // Asserts reset just after an edge; outputs are checked half a cycle later.
  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    base = cyc;
    expect_at(0, nm, MALL, 1'b0, 4'd0, 1'b1, 2'b00, 8'h00);
    @(negedge clk);
    @(posedge clk);
  endtask

  // Edge n after release samples the word handed to the n-th send.
  task automatic release_with(input logic [9:0] w0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.din = w0;
    base = cyc;
  endtask

  task automatic send(input logic [9:0] w);
    @(negedge clk);
    bus.din = w;
  endtask

  initial begin
    bus.din = '0;

    // Aligned token stream: search walks offsets 1..9,0 and locks at edge 18.
    do_reset("reset_state");
    release_with(T00);
    expect_at(17,   "s0_prelock",   ML,              1'b0, 4'd0, 1'b1, 2'b00, 8'h00);
    expect_at(18,   "s0_lock",      MALL,            1'b1, 4'd0, 1'b1, 2'b00, 8'h00);
    expect_at(20,   "dec_100",      ML|MB|MC|MD,     1'b1, 4'd0, 1'b0, 2'b00, 8'h00);
    expect_at(21,   "dec_200",      MB|MD,           1'b1, 4'd0, 1'b0, 2'b00, 8'hFF);
    expect_at(22,   "dec_1f0",      MB|MD,           1'b1, 4'd0, 1'b0, 2'b00, 8'h10);
    expect_at(23,   "dec_2c3",      MB|MD,           1'b1, 4'd0, 1'b0, 2'b00, 8'hBA);
    expect_at(24,   "tok01",        MB|MC|MD,        1'b1, 4'd0, 1'b1, 2'b01, 8'h00);
    expect_at(25,   "tok10",        MB|MC|MD,        1'b1, 4'd0, 1'b1, 2'b10, 8'h00);
    expect_at(26,   "tok11",        MB|MC|MD,        1'b1, 4'd0, 1'b1, 2'b11, 8'h00);
    expect_at(27,   "hold_c",       MB|MC|MD,        1'b1, 4'd0, 1'b0, 2'b11, 8'h00);
    expect_at(28,   "tok00",        MB|MC|MD,        1'b1, 4'd0, 1'b1, 2'b00, 8'h00);
    expect_at(4123, "loss_4095",    ML|MB|MD,        1'b1, 4'd0, 1'b0, 2'b00, 8'hFE);
    expect_at(4124, "tok_at_limit", ML|MB|MC,        1'b1, 4'd0, 1'b1, 2'b00, 8'h00);
    expect_at(8219, "loss_pre",     ML|MB|MD,        1'b1, 4'd0, 1'b0, 2'b00, 8'hFE);
    expect_at(8220, "loss_drop",    MALL,            1'b0, 4'd0, 1'b1, 2'b00, 8'h00);
    for (int k = 1; k <= 16; k++) send(T00);
    send(10'h100);
    send(10'h200);
    send(10'h1F0);
    send(10'h2C3);
    send(T01);
    send(T10);
    send(T11);
    send(10'h100);
    send(T00);
    for (int k = 0; k < 4095; k++) send(10'h000);
    send(T00);
    for (int k = 0; k < 4101; k++) send(10'h000);

    // Reset while searching after loss, then token stream at offset 3.
    do_reset("reset_async");
    release_with(S3_FIRST);
    expect_at(1,  "s3_step1", ML|MO,  1'b0, 4'd1, 1'b1, 2'b00, 8'h00);
    expect_at(2,  "s3_step2", MO,     1'b0, 4'd2, 1'b1, 2'b00, 8'h00);
    expect_at(3,  "s3_step3", ML|MO,  1'b0, 4'd3, 1'b1, 2'b00, 8'h00);
    expect_at(10, "s3_run7",  ML|MO,  1'b0, 4'd3, 1'b1, 2'b00, 8'h00);
    expect_at(11, "s3_lock",  MALL,   1'b1, 4'd3, 1'b1, 2'b00, 8'h00);
    for (int k = 1; k <= 12; k++) send(S3_WORD);

    // Seven tokens at offset 3, one broken symbol, then tokens again.
    do_reset("reset_locked");
    release_with(S3_FIRST);
    expect_at(10, "brk_run7",    ML|MO, 1'b0, 4'd3, 1'b1, 2'b00, 8'h00);
    expect_at(11, "brk_advance", ML|MO, 1'b0, 4'd4, 1'b1, 2'b00, 8'h00);
    expect_at(12, "brk_walk",    MO,    1'b0, 4'd5, 1'b1, 2'b00, 8'h00);
    expect_at(20, "brk_back3",   ML|MO, 1'b0, 4'd3, 1'b1, 2'b00, 8'h00);
    expect_at(27, "brk_prelock", ML,    1'b0, 4'd3, 1'b1, 2'b00, 8'h00);
    expect_at(28, "brk_relock",  MALL,  1'b1, 4'd3, 1'b1, 2'b00, 8'h00);
    for (int k = 1; k <= 7; k++) send(S3_WORD);
    send(10'h006);
    for (int k = 9; k <= 30; k++) send(S3_WORD);

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s never sampled actual=pending required=cycle %0d", sb[0].name, sb[0].tag);
      void'(sb.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
